// File: rtl/seg_display_capture.sv
// Receive side of the multiplexed 7-segment bus: waits for each strobed digit to settle, decodes
// it back to BCD, assembles HH:MM frames and publishes stable ones on a valid/ready port.
module seg_display_capture #(
   parameter int SETTLE_CYCLES  = 4,    // must be >= 2
   parameter int STABLE_FRAMES  = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        i_Clock,
   input  logic        i_Reset,
   input  logic [7:0]  i_Segments,
   input  logic [3:0]  i_Digits,
   output logic [15:0] o_Time,
   output logic        o_Valid,
   input  logic        i_Ready,
   output logic        o_Dot_Err,
   output logic        o_Seg_Err,
   output logic        o_Strobe_Err,
   output logic        o_Overrun,
   output logic        o_Stale,
   output logic [1:0]  o_Fsm_State
);

   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam int MW = $clog2(STABLE_FRAMES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [MW-1:0] MATCH_MAX   = MW'(STABLE_FRAMES);
   localparam logic [TW-1:0] STALE_MAX   = TW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      seg_q;
   logic [3:0]      dig_q, dig_prev;
   logic [15:0]     slots_q, slots_new, hist_q, last_pub_q;
   logic [3:0]      mask_q, mask_new;
   logic            hist_valid_q, pub_valid_q;
   logic [MW-1:0]   match_q, match_new;
   logic [TW-1:0]   stale_cnt_q;
   logic            onehot, multi, changed, capture;
   logic [1:0]      slot_idx;
   logic [4:0]      dec;
   logic            dig_legal, dig_blank, dot_req;
   logic            frame_done, frame_same, publish;

   // Returns {legal digit, BCD code}; anything but an exact 0-9 pattern decodes to 4'hF.
   function automatic logic [4:0] decode_seg(input logic [6:0] pat);
      logic [4:0] r;
      case (pat)
         7'h3F:   r = {1'b1, 4'd0};
         7'h06:   r = {1'b1, 4'd1};
         7'h5B:   r = {1'b1, 4'd2};
         7'h4F:   r = {1'b1, 4'd3};
         7'h66:   r = {1'b1, 4'd4};
         7'h6D:   r = {1'b1, 4'd5};
         7'h7D:   r = {1'b1, 4'd6};
         7'h07:   r = {1'b1, 4'd7};
         7'h7F:   r = {1'b1, 4'd8};
         7'h6F:   r = {1'b1, 4'd9};
         default: r = {1'b0, 4'hF};
      endcase
      return r;
   endfunction

   assign onehot      = (dig_q != 4'd0) && ((dig_q & (dig_q - 4'd1)) == 4'd0);
   assign multi       = (dig_q != 4'd0) && !onehot;
   assign changed     = (dig_q != dig_prev);
   assign o_Stale     = (stale_cnt_q >= STALE_MAX);
   assign o_Fsm_State = state_q;

   always_comb begin
      slot_idx = 2'd0;
      case (dig_q)
         4'b1000: slot_idx = 2'd3;
         4'b0100: slot_idx = 2'd2;
         4'b0010: slot_idx = 2'd1;
         default: slot_idx = 2'd0;
      endcase
   end

   // A one-hot strobe first seen in WAIT/HOLD/SETTLE counts as cycle 1 of its settle window.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      case (state_q)
         ST_WAIT: begin
            if (onehot) begin
               state_d = ST_SETTLE;
               cnt_d   = CW'(1);
            end
         end
         ST_SETTLE: begin
            if (changed) begin
               if (onehot) cnt_d = CW'(1);
               else        state_d = ST_WAIT;
            end else if (cnt_q >= SETTLE_LAST) begin
               capture = 1'b1;
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_HOLD: begin
            if (changed) begin
               if (onehot) begin
                  state_d = ST_SETTLE;
                  cnt_d   = CW'(1);
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         default: state_d = ST_WAIT;
      endcase
   end

   always_comb begin
      dec       = decode_seg(seg_q[6:0]);
      dig_legal = dec[4];
      dig_blank = (seg_q[6:0] == 7'h00);
      dot_req   = (slot_idx == 2'd2);
      slots_new = slots_q;
      mask_new  = mask_q;
      if (capture) begin
         slots_new[{slot_idx, 2'b00} +: 4] = dec[3:0];
         mask_new[slot_idx]                = 1'b1;
      end
      frame_done = capture && (mask_new == 4'hF);
      frame_same = hist_valid_q && (slots_new == hist_q);
      if (!frame_same)              match_new = MW'(1);
      else if (match_q == MATCH_MAX) match_new = match_q;
      else                          match_new = match_q + MW'(1);
      publish = frame_done && (match_new == MATCH_MAX) &&
                (!pub_valid_q || (slots_new != last_pub_q));
   end

   // Handshake: a frame transfers on every cycle with o_Valid && i_Ready (i_Ready is used
   // unregistered); while o_Valid && !i_Ready, o_Time is frozen and newer frames are dropped.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         seg_q        <= 8'd0;
         dig_q        <= 4'd0;
         dig_prev     <= 4'd0;
         state_q      <= ST_WAIT;
         cnt_q        <= '0;
         slots_q      <= 16'd0;
         mask_q       <= 4'd0;
         hist_q       <= 16'd0;
         hist_valid_q <= 1'b0;
         match_q      <= '0;
         last_pub_q   <= 16'd0;
         pub_valid_q  <= 1'b0;
         stale_cnt_q  <= '0;
         o_Time       <= 16'd0;
         o_Valid      <= 1'b0;
         o_Dot_Err    <= 1'b0;
         o_Seg_Err    <= 1'b0;
         o_Strobe_Err <= 1'b0;
         o_Overrun    <= 1'b0;
      end else begin
         seg_q        <= i_Segments;
         dig_q        <= i_Digits;
         dig_prev     <= dig_q;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         slots_q      <= slots_new;
         mask_q       <= frame_done ? 4'd0 : mask_new;
         o_Strobe_Err <= multi;
         o_Seg_Err    <= capture && !dig_legal && !dig_blank;
         o_Dot_Err    <= capture && dig_legal && (seg_q[7] != dot_req);
         o_Overrun    <= publish && o_Valid && !i_Ready;
         if (frame_done) begin
            hist_q       <= slots_new;
            hist_valid_q <= 1'b1;
            match_q      <= match_new;
         end
         if (publish && (!o_Valid || i_Ready)) begin
            o_Time      <= slots_new;
            o_Valid     <= 1'b1;
            last_pub_q  <= slots_new;
            pub_valid_q <= 1'b1;
         end else if (o_Valid && i_Ready) begin
            o_Valid <= 1'b0;
         end
         if (changed)                     stale_cnt_q <= '0;
         else if (stale_cnt_q != STALE_MAX) stale_cnt_q <= stale_cnt_q + TW'(1);
      end
   end

endmodule
